// File: rtl/data_mem_access.sv
// Data-side AXI4 master for the RV32I core: one single-beat load or store at a time,
// with lane steering for stores and sign/zero extension for loads.
module data_mem_access #(
    parameter int unsigned C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH      = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH      = 32,
    parameter int unsigned C_M_AXI_AWUSER_WIDTH    = 1,
    parameter int unsigned C_M_AXI_ARUSER_WIDTH    = 1,
    parameter int unsigned C_M_AXI_WUSER_WIDTH     = 4,
    parameter int unsigned C_M_AXI_RUSER_WIDTH     = 4,
    parameter int unsigned C_M_AXI_BUSER_WIDTH     = 1
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               REQ_VALID,
    input  logic                               REQ_WE,
    input  logic [2:0]                         REQ_FUNCT3,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      REQ_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      REQ_WDATA,
    output logic                               MEM_WAIT,
    output logic                               RESP_VALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      RESP_RDATA,
    output logic                               RESP_ERR,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
    output logic [7:0]                         M_AXI_AWLEN,
    output logic [2:0]                         M_AXI_AWSIZE,
    output logic [1:0]                         M_AXI_AWBURST,
    output logic                               M_AXI_AWLOCK,
    output logic [3:0]                         M_AXI_AWCACHE,
    output logic [2:0]                         M_AXI_AWPROT,
    output logic [3:0]                         M_AXI_AWQOS,
    output logic [C_M_AXI_AWUSER_WIDTH-1:0]    M_AXI_AWUSER,
    output logic                               M_AXI_AWVALID,
    input  logic                               M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
    output logic                               M_AXI_WLAST,
    output logic [C_M_AXI_WUSER_WIDTH-1:0]     M_AXI_WUSER,
    output logic                               M_AXI_WVALID,
    input  logic                               M_AXI_WREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID,
    input  logic [1:0]                         M_AXI_BRESP,
    input  logic [C_M_AXI_BUSER_WIDTH-1:0]     M_AXI_BUSER,
    input  logic                               M_AXI_BVALID,
    output logic                               M_AXI_BREADY,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARLOCK,
    output logic [3:0]                         M_AXI_ARCACHE,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic [3:0]                         M_AXI_ARQOS,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic [C_M_AXI_RUSER_WIDTH-1:0]     M_AXI_RUSER,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ar_valid_q, ar_valid_d;
    logic        r_ready_q, r_ready_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        b_ready_q, b_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        misaligned;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        aw_done;
    logic        w_done;
    logic        unused;

    assign unused = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_RID, M_AXI_RLAST, M_AXI_RUSER};

    // Alignment check on the incoming request; unsupported funct3 is rejected the same way
    always_comb begin
        misaligned = 1'b1;
        case (REQ_FUNCT3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = REQ_ADDR[0];
            3'b010:         misaligned = |REQ_ADDR[1:0];
            default:        misaligned = 1'b1;
        endcase
    end

    // Store lane steering: replicate the datum and enable only its byte lanes
    always_comb begin
        st_data = REQ_WDATA;
        st_strb = 4'b1111;
        case (REQ_FUNCT3[1:0])
            2'b00: begin
                st_data = {4{REQ_WDATA[7:0]}};
                st_strb = 4'b0001 << REQ_ADDR[1:0];
            end
            2'b01: begin
                st_data = {2{REQ_WDATA[15:0]}};
                st_strb = 4'b0011 << {REQ_ADDR[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Load extraction from the returned beat using the latched offset and size
    always_comb begin
        ld_byte = M_AXI_RDATA[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? M_AXI_RDATA[31:16] : M_AXI_RDATA[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = M_AXI_RDATA;
        endcase
    end

    assign aw_done = !aw_valid_q || M_AXI_AWREADY;
    assign w_done  = !w_valid_q  || M_AXI_WREADY;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        ar_valid_d   = ar_valid_q;
        r_ready_d    = r_ready_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        b_ready_d    = b_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    addr_d   = REQ_ADDR;
                    funct3_d = REQ_FUNCT3;
                    wdata_d  = st_data;
                    wstrb_d  = st_strb;
                    if (misaligned) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = 1'b1;
                    end else if (REQ_WE) begin
                        state_d    = WR_REQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RD_ADDR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    r_ready_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_ext;
                    resp_err_d   = (M_AXI_RRESP != 2'b00);
                    state_d      = DONE;
                end
            end
            WR_REQ: begin
                // Address and data handshakes complete independently, in any order
                if (aw_valid_q && M_AXI_AWREADY) aw_valid_d = 1'b0;
                if (w_valid_q && M_AXI_WREADY)   w_valid_d  = 1'b0;
                if (aw_done && w_done) begin
                    b_ready_d = 1'b1;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    b_ready_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = (M_AXI_BRESP != 2'b00);
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            funct3_q     <= 3'd0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            ar_valid_q   <= ar_valid_d;
            r_ready_q    <= r_ready_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            b_ready_q    <= b_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Stall holds the pipeline until the completion cycle
    assign MEM_WAIT   = REQ_VALID && (state_q != DONE);
    assign RESP_VALID = resp_valid_q;
    assign RESP_RDATA = resp_rdata_q;
    assign RESP_ERR   = resp_err_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = {addr_q[31:2], 2'b00};
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'd0;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_AWUSER  = '0;
    assign M_AXI_AWVALID = aw_valid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_WUSER   = '0;
    assign M_AXI_WVALID  = w_valid_q;
    assign M_AXI_BREADY  = b_ready_q;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = {addr_q[31:2], 2'b00};
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARUSER  = '0;
    assign M_AXI_ARVALID = ar_valid_q;
    assign M_AXI_RREADY  = r_ready_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: a small reactive AXI slave with per-channel
// ready delays, and hand-computed expectations for each access.
module tb_data_mem_access;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_WE = 1'b0;
    logic [2:0]  REQ_FUNCT3 = 3'd0;
    logic [31:0] REQ_ADDR = 32'd0;
    logic [31:0] REQ_WDATA = 32'd0;
    logic        MEM_WAIT, RESP_VALID, RESP_ERR;
    logic [31:0] RESP_RDATA;

    logic [0:0]  M_AXI_AWID, M_AXI_ARID, M_AXI_AWUSER, M_AXI_ARUSER;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
    logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
    logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWPROT, M_AXI_ARPROT;
    logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_AWLOCK, M_AXI_ARLOCK;
    logic [3:0]  M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_AWQOS, M_AXI_ARQOS;
    logic [3:0]  M_AXI_WSTRB, M_AXI_WUSER, M_AXI_RUSER;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_WLAST;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY, M_AXI_RLAST;
    logic [0:0]  M_AXI_BID, M_AXI_RID, M_AXI_BUSER;

    data_mem_access dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_FUNCT3(REQ_FUNCT3),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .MEM_WAIT(MEM_WAIT), .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 CLK = ~CLK;

    // Slave knobs and state
    logic [31:0] s_rdata = 32'd0;
    logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
    int          ar_dly = 0, aw_dly = 0, w_dly = 0;
    int          ar_cnt, aw_cnt, w_cnt;
    logic        s_rvalid, s_bvalid, aw_got, w_got;

    assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_dly);
    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
    assign M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= w_dly);
    assign M_AXI_RVALID  = s_rvalid;
    assign M_AXI_RDATA   = s_rdata;
    assign M_AXI_RRESP   = s_rresp;
    assign M_AXI_BVALID  = s_bvalid;
    assign M_AXI_BRESP   = s_bresp;
    assign M_AXI_BID     = 1'b0;
    assign M_AXI_BUSER   = 1'b0;
    assign M_AXI_RID     = 1'b0;
    assign M_AXI_RLAST   = 1'b1;
    assign M_AXI_RUSER   = 4'd0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
            s_rvalid <= 1'b0; s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
            aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (M_AXI_WVALID  && !M_AXI_WREADY)  ? w_cnt + 1  : 0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) s_rvalid <= 1'b1;
            else if (s_rvalid && M_AXI_RREADY)  s_rvalid <= 1'b0;
            if (s_bvalid && M_AXI_BREADY) begin
                s_bvalid <= 1'b0;
            end else if ((aw_got || (M_AXI_AWVALID && M_AXI_AWREADY)) &&
                         (w_got  || (M_AXI_WVALID  && M_AXI_WREADY))) begin
                s_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                aw_got <= aw_got || (M_AXI_AWVALID && M_AXI_AWREADY);
                w_got  <= w_got  || (M_AXI_WVALID  && M_AXI_WREADY);
            end
        end
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Observations collected per request
    int          lat, waits, aw_last, w_last, viol;
    logic        ar_seen, aw_seen, w_lastbit, r_err;
    logic [31:0] ar_addr, aw_addr, w_data, r_data;
    logic [3:0]  w_strb;

    // Issue one request at posedge+1, observe each cycle at the falling edge (cycle 1 = acceptance)
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        logic done, p_ar, p_aw, p_w;
        REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wd;
        lat = 0; waits = 0; aw_last = 0; w_last = 0; viol = 0;
        ar_seen = 0; aw_seen = 0; w_lastbit = 0; r_err = 0;
        ar_addr = 0; aw_addr = 0; w_data = 0; w_strb = 0; r_data = 0;
        done = 0; p_ar = 0; p_aw = 0; p_w = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge CLK);
            if (p_ar && !M_AXI_ARVALID) viol++;
            if (p_aw && !M_AXI_AWVALID) viol++;
            if (p_w  && !M_AXI_WVALID)  viol++;
            p_ar = M_AXI_ARVALID && !M_AXI_ARREADY;
            p_aw = M_AXI_AWVALID && !M_AXI_AWREADY;
            p_w  = M_AXI_WVALID  && !M_AXI_WREADY;
            if (MEM_WAIT) waits++;
            if (M_AXI_ARVALID) begin ar_seen = 1; ar_addr = M_AXI_ARADDR; end
            if (M_AXI_AWVALID) begin aw_seen = 1; aw_addr = M_AXI_AWADDR; aw_last = c; end
            if (M_AXI_WVALID) begin
                w_data = M_AXI_WDATA; w_strb = M_AXI_WSTRB; w_lastbit = M_AXI_WLAST; w_last = c;
            end
            if (RESP_VALID) begin done = 1; lat = c; r_data = RESP_RDATA; r_err = RESP_ERR; end
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
    endtask

    int resp_seen;

    initial begin
        #1 RST = 1'b0;
        #1;
        check("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        check("rst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
        check("rst_wvalid",  32'(M_AXI_WVALID),  32'd0);
        check("rst_ready",   32'({M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
        check("rst_resp",    32'({RESP_VALID, RESP_ERR}), 32'd0);
        check("rst_rdata",   RESP_RDATA, 32'd0);
        check("rst_memwait", 32'(MEM_WAIT), 32'd0);
        check("const_ar", 32'({M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE}),
              32'({8'd0, 3'b010, 2'b01, 4'b0011}));
        check("const_aw", 32'({M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWCACHE}),
              32'({8'd0, 3'b010, 2'b01, 4'b0011}));
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;

        // LW aligned, zero-wait slave
        s_rdata = 32'hDEADBEEF;
        do_req(1'b0, 3'b010, 32'h0000_0104, 32'd0);
        check("lw_araddr", ar_addr, 32'h0000_0104);
        check("lw_rdata",  r_data, 32'hDEADBEEF);
        check("lw_err",    32'(r_err), 32'd0);
        check("lw_lat",    32'(lat), 32'd4);
        check("lw_waits",  32'(waits), 32'd3);

        // Byte/half extraction and extension
        s_rdata = 32'h8011_2233;
        do_req(1'b0, 3'b000, 32'h0000_0203, 32'd0);
        check("lb_rdata",  r_data, 32'hFFFF_FF80);
        check("lb_araddr", ar_addr, 32'h0000_0200);
        do_req(1'b0, 3'b100, 32'h0000_0203, 32'd0);
        check("lbu_rdata", r_data, 32'h0000_0080);
        do_req(1'b0, 3'b101, 32'h0000_0202, 32'd0);
        check("lhu_rdata", r_data, 32'h0000_8011);
        do_req(1'b0, 3'b001, 32'h0000_0202, 32'd0);
        check("lh_rdata",  r_data, 32'hFFFF_8011);
        do_req(1'b0, 3'b001, 32'h0000_0200, 32'd0);
        check("lh0_rdata", r_data, 32'h0000_2233);
        do_req(1'b0, 3'b000, 32'h0000_0201, 32'd0);
        check("lb1_rdata", r_data, 32'h0000_0022);

        // SH with AWREADY two cycles ahead of WREADY
        aw_dly = 1; w_dly = 3;
        do_req(1'b1, 3'b001, 32'h0000_0302, 32'h1234_ABCD);
        check("sh_awaddr",  aw_addr, 32'h0000_0300);
        check("sh_wdata",   w_data, 32'hABCD_ABCD);
        check("sh_wstrb",   32'(w_strb), 32'h0000_000C);
        check("sh_wlast",   32'(w_lastbit), 32'd1);
        check("sh_aw_last", 32'(aw_last), 32'd3);
        check("sh_w_last",  32'(w_last), 32'd5);
        check("sh_lat",     32'(lat), 32'd7);
        check("sh_viol",    32'(viol), 32'd0);
        check("sh_rdata",   r_data, 32'd0);
        aw_dly = 0; w_dly = 0;

        // SH with WREADY ahead of AWREADY
        aw_dly = 2; w_dly = 0;
        do_req(1'b1, 3'b001, 32'h0000_0300, 32'h0000_5A5A);
        check("sh2_wstrb", 32'(w_strb), 32'h0000_0003);
        check("sh2_order", 32'({aw_last > w_last}), 32'd1);
        check("sh2_viol",  32'(viol), 32'd0);
        aw_dly = 0;

        // SB, simultaneous handshakes
        do_req(1'b1, 3'b000, 32'h0000_0401, 32'h0000_00A5);
        check("sb_wdata", w_data, 32'hA5A5_A5A5);
        check("sb_wstrb", 32'(w_strb), 32'h0000_0002);
        check("sb_lat",   32'(lat), 32'd4);
        check("sb_err",   32'(r_err), 32'd0);

        // Misaligned and unsupported requests never reach the bus
        do_req(1'b0, 3'b010, 32'h0000_0101, 32'd0);
        check("mis_lw_ar",  32'(ar_seen), 32'd0);
        check("mis_lw_err", 32'(r_err), 32'd1);
        check("mis_lw_lat", 32'(lat), 32'd2);
        check("mis_lw_rd",  r_data, 32'd0);
        do_req(1'b1, 3'b001, 32'h0000_0301, 32'hFFFF_FFFF);
        check("mis_sh_aw",  32'(aw_seen), 32'd0);
        check("mis_sh_err", 32'(r_err), 32'd1);
        do_req(1'b0, 3'b011, 32'h0000_0100, 32'd0);
        check("bad_f3_err", 32'(r_err), 32'd1);
        check("bad_f3_lat", 32'(lat), 32'd2);

        // SW with SLVERR, then a back-to-back LW
        s_bresp = 2'b10;
        do_req(1'b1, 3'b010, 32'h0000_0400, 32'h1122_3344);
        check("sw_err",   32'(r_err), 32'd1);
        check("sw_wstrb", 32'(w_strb), 32'h0000_000F);
        check("sw_wdata", w_data, 32'h1122_3344);
        s_bresp = 2'b00;
        s_rdata = 32'hCAFE_F00D;
        do_req(1'b0, 3'b010, 32'h0000_0108, 32'd0);
        check("b2b_lat",   32'(lat), 32'd4);
        check("b2b_rdata", r_data, 32'hCAFE_F00D);
        check("b2b_err",   32'(r_err), 32'd0);

        // Read error response
        s_rresp = 2'b11;
        do_req(1'b0, 3'b010, 32'h0000_010C, 32'd0);
        check("lw_decerr", 32'(r_err), 32'd1);
        s_rresp = 2'b00;

        // Reset while in RD_DATA with RVALID pending
        s_rdata = 32'h55AA_55AA;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h0000_0110;
        repeat (3) @(negedge CLK);
        check("rst_pre_rready", 32'(M_AXI_RREADY), 32'd1);
        check("rst_pre_rvalid", 32'(M_AXI_RVALID), 32'd1);
        #1 RST = 1'b0;
        #1;
        check("mid_rst_rready",  32'(M_AXI_RREADY), 32'd0);
        check("mid_rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        check("mid_rst_resp",    32'({RESP_VALID, RESP_ERR}), 32'd0);
        check("mid_rst_rdata",   RESP_RDATA, 32'd0);
        REQ_VALID = 1'b0;
        #1;
        check("mid_rst_memwait", 32'(MEM_WAIT), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        resp_seen = 0;
        repeat (4) begin
            @(negedge CLK);
            if (RESP_VALID) resp_seen++;
        end
        check("mid_rst_no_resp", 32'(resp_seen), 32'd0);
        @(posedge CLK); #1;
        s_rdata = 32'h0BAD_F00D;
        do_req(1'b0, 3'b010, 32'h0000_0114, 32'd0);
        check("post_rst_lat",   32'(lat), 32'd4);
        check("post_rst_rdata", r_data, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
